// File: rtl/cache_line_axi_pkg.sv
// rtl/cache_line_axi_pkg.sv - shared constants and state type for the cache line AXI engine
package cache_line_axi_pkg;

  localparam int          CACHELINE_WIDTH = 256;
  localparam int          BEATS           = CACHELINE_WIDTH / 32;
  localparam int          LINE_OFFSET     = 5;
  localparam logic [3:0]  AXI_ID          = 4'd0;
  localparam logic [7:0]  AXI_LEN         = 8'(BEATS - 1);
  localparam logic [2:0]  AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0]  LAST_BEAT       = 3'(BEATS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } state_e;

  // Line-aligned byte address from a stored line index.
  function automatic logic [31:0] line_addr(input logic [31-LINE_OFFSET:0] idx);
    return {idx, {LINE_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_line_axi.sv
// rtl/cache_line_axi.sv - victim write-back and line refill over 8-beat AXI INCR bursts
module cache_line_axi
  import cache_line_axi_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_req_i,
  input  logic [31:0]                miss_addr_i,
  input  logic                       write_req_i,
  input  logic [31:0]                write_addr_i,
  input  logic [CACHELINE_WIDTH-1:0] cacheline_old_i,
  output logic                       refresh_o,
  output logic [CACHELINE_WIDTH-1:0] cacheline_new_o,
  output logic                       wb_done_o,
  output logic                       busy_o,
  output logic                       resp_err_o,
  output logic [3:0]                 arid_o,
  output logic [31:0]                araddr_o,
  output logic [7:0]                 arlen_o,
  output logic [2:0]                 arsize_o,
  output logic [1:0]                 arburst_o,
  output logic                       arvalid_o,
  input  logic                       arready_i,
  input  logic [31:0]                rdata_i,
  input  logic [1:0]                 rresp_i,
  input  logic                       rlast_i,
  input  logic                       rvalid_i,
  output logic                       rready_o,
  output logic [3:0]                 awid_o,
  output logic [31:0]                awaddr_o,
  output logic [7:0]                 awlen_o,
  output logic [2:0]                 awsize_o,
  output logic [1:0]                 awburst_o,
  output logic                       awvalid_o,
  input  logic                       awready_i,
  output logic [31:0]                wdata_o,
  output logic [3:0]                 wstrb_o,
  output logic                       wlast_o,
  output logic                       wvalid_o,
  input  logic                       wready_i,
  input  logic [1:0]                 bresp_i,
  input  logic                       bvalid_i,
  output logic                       bready_o
);

  state_e                       state_q, state_d;
  logic [2:0]                   cnt_q, cnt_d;
  logic [31-LINE_OFFSET:0]      waddr_q, waddr_d;
  logic [31-LINE_OFFSET:0]      raddr_q, raddr_d;
  logic                         miss_pend_q, miss_pend_d;
  logic                         resp_err_q, resp_err_d;
  // One line register serves both directions: it holds the victim during
  // the write burst and is then overwritten beat by beat by the refill.
  logic [CACHELINE_WIDTH-1:0]   line_q, line_d;
  logic [7:0]                   beat_base;

  logic                         unused_addr_bits;
  assign unused_addr_bits = ^{miss_addr_i[LINE_OFFSET-1:0], write_addr_i[LINE_OFFSET-1:0]};

  assign beat_base = {cnt_q, 5'b0};

  assign arid_o          = AXI_ID;
  assign araddr_o        = line_addr(raddr_q);
  assign arlen_o         = AXI_LEN;
  assign arsize_o        = AXI_SIZE_4B;
  assign arburst_o       = AXI_BURST_INCR;
  assign awid_o          = AXI_ID;
  assign awaddr_o        = line_addr(waddr_q);
  assign awlen_o         = AXI_LEN;
  assign awsize_o        = AXI_SIZE_4B;
  assign awburst_o       = AXI_BURST_INCR;
  assign wstrb_o         = 4'hf;
  assign wdata_o         = line_q[beat_base +: 32];
  assign cacheline_new_o = line_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign resp_err_o      = resp_err_q;

  // Next-state, datapath updates and channel handshakes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    miss_pend_d = miss_pend_q;
    resp_err_d  = resp_err_q;
    line_d      = line_q;
    arvalid_o   = 1'b0;
    awvalid_o   = 1'b0;
    wvalid_o    = 1'b0;
    wlast_o     = 1'b0;
    rready_o    = 1'b0;
    bready_o    = 1'b0;
    refresh_o   = 1'b0;
    wb_done_o   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (write_req_i) begin
          waddr_d     = write_addr_i[31:LINE_OFFSET];
          line_d      = cacheline_old_i;
          miss_pend_d = miss_req_i;
          if (miss_req_i) begin
            raddr_d = miss_addr_i[31:LINE_OFFSET];
          end
          state_d = ST_AW;
        end else if (miss_req_i) begin
          raddr_d     = miss_addr_i[31:LINE_OFFSET];
          miss_pend_d = 1'b0;
          state_d     = ST_AR;
        end
      end
      ST_AW: begin
        awvalid_o = 1'b1;
        if (awready_i) begin
          cnt_d   = 3'd0;
          state_d = ST_W;
        end
      end
      ST_W: begin
        wvalid_o = 1'b1;
        wlast_o  = (cnt_q == LAST_BEAT);
        if (wready_i) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_B;
          end
        end
      end
      ST_B: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          wb_done_o = 1'b1;
          if (bresp_i != 2'b00) begin
            resp_err_d = 1'b1;
          end
          miss_pend_d = 1'b0;
          state_d     = miss_pend_q ? ST_AR : ST_IDLE;
        end
      end
      ST_AR: begin
        arvalid_o = 1'b1;
        if (arready_i) begin
          cnt_d   = 3'd0;
          state_d = ST_R;
        end
      end
      ST_R: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          line_d[beat_base +: 32] = rdata_i;
          // The burst always completes on the beat count; a misplaced
          // rlast is only reported.
          if ((rresp_i != 2'b00) || (rlast_i != (cnt_q == LAST_BEAT))) begin
            resp_err_d = 1'b1;
          end
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        refresh_o = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      miss_pend_q <= 1'b0;
      resp_err_q  <= 1'b0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      miss_pend_q <= miss_pend_d;
      resp_err_q  <= resp_err_d;
      line_q      <= line_d;
    end
  end

endmodule

// File: tb/tb_cache_line_axi.sv
// tb/tb_cache_line_axi.sv - directed bench with AXI slave and behavioural checker for cache_line_axi
module tb_cache_line_axi;

  logic         clk;
  logic         rst;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         write_req;
  logic [31:0]  write_addr;
  logic [255:0] cacheline_old;
  logic         refresh;
  logic [255:0] cacheline_new;
  logic         wb_done;
  logic         busy;
  logic         resp_err;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  cache_line_axi dut (
    .clk(clk), .rst(rst),
    .miss_req_i(miss_req), .miss_addr_i(miss_addr),
    .write_req_i(write_req), .write_addr_i(write_addr), .cacheline_old_i(cacheline_old),
    .refresh_o(refresh), .cacheline_new_o(cacheline_new), .wb_done_o(wb_done),
    .busy_o(busy), .resp_err_o(resp_err),
    .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize),
    .arburst_o(arburst), .arvalid_o(arvalid), .arready_i(arready),
    .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid), .rready_o(rready),
    .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize),
    .awburst_o(awburst), .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
    .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Slave knobs and expectations set by the directed tests.
  logic [255:0] rline;
  logic [15:0]  rgap_pat;
  logic [15:0]  wrdy_pat;
  int           rlast_beat;
  logic [1:0]   rresp_val;
  logic [1:0]   bresp_val;
  logic [31:0]  exp_raddr;
  logic [31:0]  exp_waddr;
  logic [255:0] exp_old;
  logic [255:0] exp_new;

  // Observed transaction counters.
  int ar_cnt = 0;
  int refresh_cnt = 0;
  int wb_cnt = 0;
  int w_hs_cnt = 0;
  int r_hs_cnt = 0;

  // AXI slave: zero-wait address channels, patterned R/W flow control.
  bit s_r_active = 0;
  int s_r_beat = 0;
  int s_r_cyc = 0;
  bit s_b_pend = 0;
  int s_w_cyc = 0;
  initial begin
    arready = 1'b1; awready = 1'b1;
    rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    wready = 1'b0; bvalid = 1'b0; bresp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        s_r_active = 0; s_r_beat = 0; s_b_pend = 0;
      end else begin
        if (arvalid && arready) begin s_r_active = 1; s_r_beat = 0; s_r_cyc = 0; end
        if (rvalid && rready) begin
          s_r_beat++;
          if (s_r_beat == 8) s_r_active = 0;
        end
        if (wvalid && wready && wlast) s_b_pend = 1;
        if (bvalid && bready) s_b_pend = 0;
      end
      @(posedge clk); #1;
      if (s_r_active) begin
        rvalid = rgap_pat[s_r_cyc % 16];
        s_r_cyc++;
        rdata  = rline[s_r_beat*32 +: 32];
        rlast  = (s_r_beat == rlast_beat);
        rresp  = rresp_val;
      end else begin
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      end
      bvalid = s_b_pend;
      bresp  = s_b_pend ? bresp_val : 2'b00;
      wready = wrdy_pat[s_w_cyc % 16];
      s_w_cyc++;
    end
  end

  // Behavioural checker: per-cycle protocol, data and sticky error model.
  int  m_w_beat = 0;
  int  m_r_beat = 0;
  bit  model_err = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_w_beat = 0; m_r_beat = 0; model_err = 0;
      end else begin
        chk("resp_err", {255'd0, resp_err}, {255'd0, model_err});
        if (arvalid)
          chk("ar_fields", {arid, araddr, arlen, arsize, arburst},
              {4'd0, exp_raddr, 8'd7, 3'b010, 2'b01});
        if (awvalid)
          chk("aw_fields", {awid, awaddr, awlen, awsize, awburst, wvalid},
              {4'd0, exp_waddr, 8'd7, 3'b010, 2'b01, 1'b0});
        if (wvalid)
          chk("w_beat", {wdata, wstrb, wlast},
              {exp_old[m_w_beat*32 +: 32], 4'hf, (m_w_beat == 7) ? 1'b1 : 1'b0});
        if (refresh) begin
          chk("refresh_line", cacheline_new, exp_new);
          refresh_cnt++;
        end
        if (wb_done) wb_cnt++;
        if (arvalid && arready) begin ar_cnt++; m_r_beat = 0; end
        if (awvalid && awready) m_w_beat = 0;
        if (wvalid && wready) begin m_w_beat = (m_w_beat + 1) % 8; w_hs_cnt++; end
        if (rvalid && rready) begin
          if (rresp != 2'b00 || rlast != (m_r_beat == 7)) model_err = 1;
          m_r_beat = (m_r_beat + 1) % 8;
          r_hs_cnt++;
        end
        if (bvalid && bready && bresp != 2'b00) model_err = 1;
      end
    end
  end

  // Wait for refresh (which==0) or wb_done (which==1); n counts clock edges.
  task automatic wait_for(input int which, input int max, output int n, output bit busy_dropped);
    n = 0;
    busy_dropped = 0;
    forever begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!busy) busy_dropped = 1;
      if ((which == 0) ? refresh : wb_done) return;
      if (n >= max) begin
        n_total++;
        $display("FAIL timeout waiting for %s after %0d cycles", (which == 0) ? "refresh" : "wb_done", n);
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int n;
  int n2;
  int base;
  int hs;
  bit dropped;

  initial begin
    rst = 1'b1; miss_req = 0; miss_addr = '0; write_req = 0; write_addr = '0; cacheline_old = '0;
    rline = '0; rgap_pat = 16'hffff; wrdy_pat = 16'hffff; rlast_beat = 7;
    rresp_val = 2'b00; bresp_val = 2'b00;
    exp_raddr = '0; exp_waddr = '0; exp_old = '0; exp_new = '0;
    do_reset();

    // Reset state.
    @(negedge clk);
    chk("reset_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'd0);
    chk("reset_busy", {255'd0, busy}, 256'd0);
    chk("reset_pulses", {refresh, wb_done}, 2'd0);
    chk("reset_err", {255'd0, resp_err}, 256'd0);
    chk("reset_line", cacheline_new, 256'd0);

    // T1: plain refill, zero-wait slave.
    for (int k = 0; k < 8; k++) rline[k*32 +: 32] = 32'ha0000000 + k;
    exp_new = rline;
    exp_raddr = 32'h1fc00120;
    @(posedge clk); #1;
    miss_req = 1'b1; miss_addr = 32'h1fc00124;
    wait_for(0, 40, n, dropped);
    miss_req = 1'b0;
    chk("t1_latency", n, 10);
    chk("t1_busy_held", {255'd0, dropped}, 256'd0);
    chk("t1_beat1", cacheline_new[63:32], 32'ha0000001);
    chk("t1_beat7", cacheline_new[255:224], 32'ha0000007);
    @(posedge clk); @(negedge clk);
    chk("t1_refresh_once", {refresh, busy}, 2'b00);
    chk("t1_counts", {ar_cnt[7:0], refresh_cnt[7:0]}, {8'd1, 8'd1});

    // T2: write-back and refill requested together.
    for (int k = 0; k < 8; k++) exp_old[k*32 +: 32] = k * 32'h11111111;
    for (int k = 0; k < 8; k++) rline[k*32 +: 32] = 32'hb0000000 + (k << 4);
    exp_new = rline;
    exp_waddr = 32'h00001f40;
    exp_raddr = 32'h00002a00;
    base = w_hs_cnt;
    @(posedge clk); #1;
    write_req = 1'b1; write_addr = 32'h00001f5c; cacheline_old = exp_old;
    miss_req = 1'b1; miss_addr = 32'h00002a1c;
    @(posedge clk); #1;
    cacheline_old = ~exp_old; write_addr = 32'hdeadbeef;
    wait_for(1, 60, n, dropped);
    write_req = 1'b0;
    chk("t2_wb_latency", n + 1, 10);
    chk("t2_no_ar_before_wb", ar_cnt, 1);
    chk("t2_w_beats", w_hs_cnt - base, 8);
    wait_for(0, 60, n2, dropped);
    miss_req = 1'b0;
    chk("t2_refill_latency", n2, 10);
    chk("t2_no_idle_between", {255'd0, dropped}, 256'd0);
    chk("t2_counts", {ar_cnt[7:0], wb_cnt[7:0], refresh_cnt[7:0]}, {8'd2, 8'd1, 8'd2});

    // T3: write-back alone with wready toggling.
    for (int k = 0; k < 8; k++) exp_old[k*32 +: 32] = 32'h12345600 + k * 32'h01010101;
    exp_waddr = 32'h00008000;
    wrdy_pat = 16'h5555;
    base = w_hs_cnt;
    @(posedge clk); #1;
    write_req = 1'b1; write_addr = 32'h0000801f; cacheline_old = exp_old;
    wait_for(1, 80, n, dropped);
    write_req = 1'b0;
    chk("t3_w_beats", w_hs_cnt - base, 8);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("t3_idle_after", {255'd0, busy}, 256'd0);
    chk("t3_no_ar", ar_cnt, 2);
    chk("t3_wb_cnt", wb_cnt, 2);
    wrdy_pat = 16'hffff;

    // T4: rvalid gaps and early rlast on beat 5.
    for (int k = 0; k < 8; k++) rline[k*32 +: 32] = 32'hc0de0000 + k * 32'h00000101;
    exp_new = rline;
    exp_raddr = 32'h40000040;
    rgap_pat = 16'b1011_0110_1101_0011;
    rlast_beat = 5;
    base = r_hs_cnt;
    @(posedge clk); #1;
    miss_req = 1'b1; miss_addr = 32'h40000048;
    wait_for(0, 100, n, dropped);
    miss_req = 1'b0;
    chk("t4_r_beats", r_hs_cnt - base, 8);
    chk("t4_err_set", {255'd0, resp_err}, 256'd1);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("t4_err_sticky", {255'd0, resp_err}, 256'd1);
    rgap_pat = 16'hffff;
    rlast_beat = 7;

    // T5: error B response, then a clean refill.
    do_reset();
    @(negedge clk);
    chk("t5_err_cleared", {255'd0, resp_err}, 256'd0);
    exp_old = {8{32'h5a5a0f0f}};
    exp_waddr = 32'h00000100;
    bresp_val = 2'b10;
    @(posedge clk); #1;
    write_req = 1'b1; write_addr = 32'h00000104; cacheline_old = exp_old;
    wait_for(1, 60, n, dropped);
    write_req = 1'b0;
    chk("t5_wb_latency", n, 10);
    @(posedge clk); @(negedge clk);
    chk("t5_err_bresp", {resp_err, busy}, 2'b10);
    bresp_val = 2'b00;
    for (int k = 0; k < 8; k++) rline[k*32 +: 32] = 32'hd0000000 ^ (k * 32'h00010001);
    exp_new = rline;
    exp_raddr = 32'h00003000;
    @(posedge clk); #1;
    miss_req = 1'b1; miss_addr = 32'h00003010;
    wait_for(0, 40, n, dropped);
    miss_req = 1'b0;
    chk("t5_refill_latency", n, 10);

    // T6: reset in the middle of the read burst.
    rline = ~rline;
    exp_new = rline;
    exp_raddr = 32'h00007fe0;
    @(posedge clk); #1;
    miss_req = 1'b1; miss_addr = 32'h00007ffc;
    hs = 0;
    for (int i = 0; i < 40 && hs < 4; i++) begin
      @(negedge clk);
      if (rvalid && rready) hs++;
    end
    chk("t6_reached_beat3", hs, 4);
    @(posedge clk); #1;
    rst = 1'b1;
    miss_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("t6_reset_valids", {arvalid, awvalid, wvalid, rready, bready, refresh}, 6'd0);
    chk("t6_reset_busy", {255'd0, busy}, 256'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    base = refresh_cnt;
    for (int k = 0; k < 8; k++) rline[k*32 +: 32] = 32'he1000000 + k * 32'h00100000;
    exp_new = rline;
    exp_raddr = 32'h00009900;
    @(posedge clk); #1;
    miss_req = 1'b1; miss_addr = 32'h00009904;
    wait_for(0, 40, n, dropped);
    miss_req = 1'b0;
    chk("t6_refill_latency", n, 10);
    chk("t6_refresh_count", refresh_cnt - base, 1);
    chk("t6_err_clean", {255'd0, resp_err}, 256'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
